regfile_32x64: RTL and testbench
================================

Name: regfile_32x64

Overview:
- 32-entry × 64-bit architectural register file for the ID stage of the 64-bit pipeline.
- Holds the storage flops and the write-enable decoder.
- Presents all 32 registers to the two 32:1 read-select trees, which are built from per-bit 32:1 muxes and live inside this block.
- The WB stage drives the write port. ID consumes ReadData1/ReadData2 for the ID/EX pipeline register.
- Register 31 is the hardwired zero register (XZR).

Parameters:
- DATA_WIDTH, 64, width of each register and of the data ports.
- NUM_REGS, 32, number of registers. Fixed by the 5-bit address.
- ZERO_REG, 31, index that always reads 0 and ignores writes.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- RegWrite  input  1  write enable from WB.
- WriteRegister  input  5  destination register index.
- WriteData  input  64  data to write.
- ReadRegister1  input  5  source index, port 1.
- ReadRegister2  input  5  source index, port 2.
- ReadData1  output  64  read data, port 1.
- ReadData2  output  64  read data, port 2.

Behaviour:
- Reset:
  - reset=0 clears all 32 registers to 0 immediately, independent of clk.
  - While reset=0, clock edges are ignored and ReadData1 = ReadData2 = 0.
  - On a rising clk edge where reset is still 0, the write is ignored.
  - The first write can occur on the first rising edge after reset goes to 1.
- Write decode:
  - Enable for reg[i] = RegWrite & (WriteRegister==i) & (i!=ZERO_REG).
  - Exactly zero or one register is enabled per cycle (one-hot decode of the 5-bit index).
- Write timing: on the rising edge of clk with the enable high, reg[i] <= WriteData. All other registers hold.
- Read path:
  - Purely combinational, no latency.
  - ReadDataN = reg[ReadRegisterN], selected bit-wise by a 32:1 mux per bit (64 instances per port).
- Zero register:
  - ReadRegisterN==31 → ReadDataN = 0, regardless of any write to 31 (writes to 31 are discarded).
  - reg[31] storage is tied to 0 / not implemented.
- Write-through bypass (WB→ID same-cycle forwarding):
  - Condition: RegWrite=1 and WriteRegister==ReadRegisterN and WriteRegister!=31.
  - When it holds, ReadDataN = WriteData combinationally in the same cycle, before the clock edge commits it.
  - Both ports may bypass simultaneously when they read the same register.
- Simultaneous events:
  - Both read ports may address the same register.
  - A read and a write to different registers do not interact.
  - A write with RegWrite=0 has no effect, whatever the WriteRegister/WriteData values.
- Reset mid-operation: the contents are lost and all registers read 0 after release. No partial-write state persists.
- Widths: no arithmetic. Indices are unsigned 5-bit and all 32 values are legal.

Test Plan:
- Reset clear:
  - Stimulus: write 64'hDEAD_BEEF_0000_1309 to X5, then pulse reset=0 between edges.
  - Required response: ReadData1 (ReadRegister1=5) becomes 0 immediately, with no clk edge needed. It stays 0 after release until rewritten.
- Write/read all:
  - Stimulus: for i=0..30, write value i*64'h0101_0101_0101_0101 to Xi. Then sweep ReadRegister1 and ReadRegister2 over 0..31.
  - Required response: each index returns its value; index 31 returns 0.
- Zero register:
  - Stimulus: RegWrite=1, WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF, then clock.
  - Required response: ReadData on index 31 = 0 before and after the edge. No other register changes.
- Bypass:
  - Stimulus: X7 holds 64'h1. Drive RegWrite=1, WriteRegister=7, WriteData=64'h2A, ReadRegister1=ReadRegister2=7.
  - Required response: both outputs = 64'h2A before the edge and after it.
  - Follow-up: drop RegWrite with no edge → outputs return to 64'h1.
- Write enable off:
  - Stimulus: RegWrite=0, WriteRegister=3, WriteData=64'h55, then clock.
  - Required response: X3 keeps its prior value and no bypass occurs.
- Write at reset release:
  - Stimulus: reset is still 0 at a rising edge with RegWrite=1, WriteRegister=4, WriteData=64'h99.
  - Required response: X4 reads 0 after release.
  - Follow-up: the same write on the next edge with reset=1 → X4 = 64'h99.

Source files
------------

// File: rtl/regfile_32x64.sv
// 32 x 64-bit architectural register file with hardwired zero register,
// per-bit 32:1 read-select trees and same-cycle WB->ID write-through bypass.

module regfile_32x64_mux #(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic [N-1:0]  d,
    input  logic [AW-1:0] sel,
    output logic          y
);
    assign y = d[sel];
endmodule

module regfile_32x64 #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [4:0]            WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);
    localparam int AW = 5;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]                 we;
    logic [DATA_WIDTH-1:0]               mux1, mux2;
    logic                                byp1, byp2;

    always_comb begin
        we = '0;
        for (int i = 0; i < NUM_REGS; i++)
            we[i] = RegWrite && (WriteRegister == AW'(i)) && (i != ZERO_REG);
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == ZERO_REG) begin : g_zero
            assign regs[r] = '0;
        end else begin : g_store
            logic [DATA_WIDTH-1:0] q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    q <= '0;
                else if (we[r])
                    q <= WriteData;
            end
            assign regs[r] = q;
        end
    end

    // Each output bit is its own 32:1 mux over the column of that bit.
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
        logic [NUM_REGS-1:0] col;
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_col
            assign col[r] = regs[r][b];
        end
        regfile_32x64_mux #(.N(NUM_REGS), .AW(AW)) u_mux1 (
            .d   (col),
            .sel (ReadRegister1),
            .y   (mux1[b])
        );
        regfile_32x64_mux #(.N(NUM_REGS), .AW(AW)) u_mux2 (
            .d   (col),
            .sel (ReadRegister2),
            .y   (mux2[b])
        );
    end

    // Bypass is gated by reset so outputs read 0 while reset is held.
    assign byp1 = reset && RegWrite && (WriteRegister == ReadRegister1) &&
                  (WriteRegister != AW'(ZERO_REG));
    assign byp2 = reset && RegWrite && (WriteRegister == ReadRegister2) &&
                  (WriteRegister != AW'(ZERO_REG));

    assign ReadData1 = byp1 ? WriteData : mux1;
    assign ReadData2 = byp2 ? WriteData : mux2;
endmodule

// File: tb/tb_regfile_32x64.sv
// Directed bench for regfile_32x64: reset, write/read sweep, XZR, bypass,
// write-enable gating and write at reset release.

module tb_regfile_32x64;
    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int nvec = 0;
    int nerr = 0;

    localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;
    localparam logic [63:0] DB   = 64'hDEAD_BEEF_0000_1309;

    regfile_32x64 dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [63:0] d);
        RegWrite = 1'b1; WriteRegister = a; WriteData = d;
        tick();
        RegWrite = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd5;
        tick();
        tick();
        nvec++;
        if (ReadData1 !== 64'h0) begin
            nerr++; $display("FAIL reset_rd1 got %h want %h", ReadData1, 64'h0);
        end
        nvec++;
        if (ReadData2 !== 64'h0) begin
            nerr++; $display("FAIL reset_rd2 got %h want %h", ReadData2, 64'h0);
        end
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset_clear();
        ReadRegister1 = 5'd5;
        do_write(5'd5, DB);
        nvec++;
        if (ReadData1 !== DB) begin
            nerr++; $display("FAIL clr_written got %h want %h", ReadData1, DB);
        end
        #1 reset = 1'b0;
        #1;
        nvec++;
        if (ReadData1 !== 64'h0) begin
            nerr++; $display("FAIL clr_async got %h want %h", ReadData1, 64'h0);
        end
        reset = 1'b1;
        #1;
        nvec++;
        if (ReadData1 !== 64'h0) begin
            nerr++; $display("FAIL clr_release got %h want %h", ReadData1, 64'h0);
        end
        tick();
        nvec++;
        if (ReadData1 !== 64'h0) begin
            nerr++; $display("FAIL clr_after_edge got %h want %h", ReadData1, 64'h0);
        end
    endtask

    task automatic test_write_read_all();
        logic [63:0] e1, e2;
        for (int i = 0; i < 31; i++) do_write(5'(i), 64'(i) * STEP);
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            e1 = (i == 31) ? 64'h0 : 64'(i) * STEP;
            e2 = (i == 0) ? 64'h0 : 64'(31 - i) * STEP;
            nvec++;
            if (ReadData1 !== e1) begin
                nerr++; $display("FAIL sweep_rd1[%0d] got %h want %h", i, ReadData1, e1);
            end
            nvec++;
            if (ReadData2 !== e2) begin
                nerr++; $display("FAIL sweep_rd2[%0d] got %h want %h", 31 - i, ReadData2, e2);
            end
        end
    endtask

    task automatic test_zero_reg();
        logic [63:0] e;
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = '1;
        ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        #1;
        nvec++;
        if (ReadData1 !== 64'h0) begin
            nerr++; $display("FAIL xzr_pre_rd1 got %h want %h", ReadData1, 64'h0);
        end
        nvec++;
        if (ReadData2 !== 64'h0) begin
            nerr++; $display("FAIL xzr_pre_rd2 got %h want %h", ReadData2, 64'h0);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        nvec++;
        if (ReadData1 !== 64'h0) begin
            nerr++; $display("FAIL xzr_post got %h want %h", ReadData1, 64'h0);
        end
        for (int i = 0; i < 31; i++) begin
            ReadRegister2 = 5'(i);
            #1;
            e = 64'(i) * STEP;
            nvec++;
            if (ReadData2 !== e) begin
                nerr++; $display("FAIL xzr_others[%0d] got %h want %h", i, ReadData2, e);
            end
        end
    endtask

    task automatic test_bypass();
        do_write(5'd7, 64'h1);
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h2A;
        #1;
        nvec++;
        if (ReadData1 !== 64'h2A) begin
            nerr++; $display("FAIL byp_pre_rd1 got %h want %h", ReadData1, 64'h2A);
        end
        nvec++;
        if (ReadData2 !== 64'h2A) begin
            nerr++; $display("FAIL byp_pre_rd2 got %h want %h", ReadData2, 64'h2A);
        end
        RegWrite = 1'b0;
        #1;
        nvec++;
        if (ReadData1 !== 64'h1) begin
            nerr++; $display("FAIL byp_drop_rd1 got %h want %h", ReadData1, 64'h1);
        end
        nvec++;
        if (ReadData2 !== 64'h1) begin
            nerr++; $display("FAIL byp_drop_rd2 got %h want %h", ReadData2, 64'h1);
        end
        RegWrite = 1'b1;
        tick();
        nvec++;
        if (ReadData1 !== 64'h2A) begin
            nerr++; $display("FAIL byp_edge_rd1 got %h want %h", ReadData1, 64'h2A);
        end
        RegWrite = 1'b0;
        #1;
        nvec++;
        if (ReadData2 !== 64'h2A) begin
            nerr++; $display("FAIL byp_commit_rd2 got %h want %h", ReadData2, 64'h2A);
        end
    endtask

    task automatic test_we_off();
        logic [63:0] e;
        e = 64'd3 * STEP;
        RegWrite = 1'b0; WriteRegister = 5'd3; WriteData = 64'h55;
        ReadRegister1 = 5'd3; ReadRegister2 = 5'd8;
        #1;
        nvec++;
        if (ReadData1 !== e) begin
            nerr++; $display("FAIL weoff_pre got %h want %h", ReadData1, e);
        end
        tick();
        nvec++;
        if (ReadData1 !== e) begin
            nerr++; $display("FAIL weoff_post got %h want %h", ReadData1, e);
        end
        nvec++;
        if (ReadData2 !== 64'd8 * STEP) begin
            nerr++; $display("FAIL weoff_other got %h want %h", ReadData2, 64'd8 * STEP);
        end
    endtask

    task automatic test_write_at_release();
        reset = 1'b0;
        RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 64'h99;
        ReadRegister1 = 5'd4; ReadRegister2 = 5'd4;
        #1;
        nvec++;
        if (ReadData1 !== 64'h0) begin
            nerr++; $display("FAIL rel_in_reset got %h want %h", ReadData1, 64'h0);
        end
        tick();
        #1 reset = 1'b1;
        RegWrite = 1'b0;
        #1;
        nvec++;
        if (ReadData1 !== 64'h0) begin
            nerr++; $display("FAIL rel_ignored got %h want %h", ReadData1, 64'h0);
        end
        RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
        #1;
        nvec++;
        if (ReadData2 !== 64'h99) begin
            nerr++; $display("FAIL rel_first_write got %h want %h", ReadData2, 64'h99);
        end
        ReadRegister1 = 5'd3;
        #1;
        nvec++;
        if (ReadData1 !== 64'h0) begin
            nerr++; $display("FAIL rel_x3_cleared got %h want %h", ReadData1, 64'h0);
        end
    endtask

    initial begin
        test_reset();
        test_reset_clear();
        test_write_read_all();
        test_zero_reg();
        test_bypass();
        test_we_off();
        test_write_at_release();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
